// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Brief    : Shares one external memory port between instruction fetch and
//            data load/store. One access outstanding at a time. Stale fetches
//            are dropped on flush, hung accesses time out, and fetch
//            starvation by back-to-back data traffic is bounded.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int MAX_WAIT     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    output logic        if_busy,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int c_WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST  = c_WAIT_W'(MAX_WAIT - 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_ONE   = c_WAIT_W'(1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);
    localparam logic [2:0]            c_FETCH_SIZE = 3'd4;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    logic [1:0]            r_state,     w_state_nxt;
    logic                  r_mem_req,   w_mem_req_nxt;
    logic                  r_mem_we,    w_mem_we_nxt;
    logic [31:0]           r_mem_addr,  w_mem_addr_nxt;
    logic [31:0]           r_mem_wdata, w_mem_wdata_nxt;
    logic [2:0]            r_mem_size,  w_mem_size_nxt;
    logic                  r_if_ready,  w_if_ready_nxt;
    logic [31:0]           r_if_data,   w_if_data_nxt;
    logic                  r_d_ready,   w_d_ready_nxt;
    logic [31:0]           r_d_rdata,   w_d_rdata_nxt;
    logic                  r_err,       w_err_nxt;
    logic [c_WAIT_W-1:0]   r_wait,      w_wait_nxt;
    logic [c_STARVE_W-1:0] r_starve,    w_starve_nxt;
    logic                  r_drop,      w_drop_nxt;
    logic                  w_grant_data;
    logic [31:0]           w_resp_data;

    // Next state and next registered outputs of the single-access FSM
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_size_nxt  = r_mem_size;
        w_if_ready_nxt  = 1'b0;
        w_if_data_nxt   = r_if_data;
        w_d_ready_nxt   = 1'b0;
        w_d_rdata_nxt   = r_d_rdata;
        w_err_nxt       = 1'b0;
        w_wait_nxt      = r_wait;
        w_starve_nxt    = r_starve;
        w_drop_nxt      = r_drop;
        w_resp_data     = '0;
        // Data wins unless the fetch side has already waited out its quota
        w_grant_data    = d_req & ~((r_starve == c_STARVE_MAX) & if_req);

        case (r_state)
            c_ST_IDLE: begin
                w_drop_nxt = 1'b0;
                w_wait_nxt = '0;
                if (w_grant_data) begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = d_we;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    w_mem_size_nxt  = d_size;
                    w_state_nxt     = c_ST_DATA;
                    if (if_req && (r_starve != c_STARVE_MAX)) begin
                        w_starve_nxt = r_starve + c_STARVE_ONE;
                    end
                end else if (if_req && !flush) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = if_addr;
                    w_mem_size_nxt = c_FETCH_SIZE;
                    w_starve_nxt   = '0;
                    w_state_nxt    = c_ST_FETCH;
                end
            end
            c_ST_FETCH, c_ST_DATA: begin
                // A redirect during a fetch marks its result stale; the
                // memory side still runs to completion
                w_drop_nxt = r_drop | ((r_state == c_ST_FETCH) & flush);
                if (mem_ack || (r_wait == c_WAIT_LAST)) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = c_ST_RESP;
                    w_resp_data   = mem_ack ? mem_rdata : 32'd0;
                    if (r_state == c_ST_FETCH) begin
                        if (!w_drop_nxt) begin
                            w_if_ready_nxt = 1'b1;
                            w_if_data_nxt  = w_resp_data;
                            w_err_nxt      = ~mem_ack;
                        end
                    end else begin
                        w_d_ready_nxt = 1'b1;
                        w_d_rdata_nxt = w_resp_data;
                        w_err_nxt     = ~mem_ack;
                    end
                end else begin
                    w_wait_nxt = r_wait + c_WAIT_ONE;
                end
            end
            c_ST_RESP: begin
                w_drop_nxt  = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= '0;
            r_if_ready  <= 1'b0;
            r_if_data   <= '0;
            r_d_ready   <= 1'b0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
            r_wait      <= '0;
            r_starve    <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_size  <= w_mem_size_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_if_data   <= w_if_data_nxt;
            r_d_ready   <= w_d_ready_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_err       <= w_err_nxt;
            r_wait      <= w_wait_nxt;
            r_starve    <= w_starve_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_size  = r_mem_size;
    assign if_ready  = r_if_ready;
    assign if_data   = r_if_data;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;
    // PC stays frozen from request until the instruction is delivered
    assign if_busy   = if_req & ~r_if_ready;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch (program counter side) and data load/store (execute side).
- Runs a one-outstanding-access state machine and drives mem_req/mem_ack handshakes.
- Supplies the busy signals that freeze the program counter and execute stage.
- Discards fetches made stale by a jump or branch, aborts hung accesses via timeout, and bounds fetch starvation.

Parameters:
MAX_WAIT, 16, cycles mem_req may stay high without mem_ack before abort (≥1)
STARVE_LIMIT, 4, consecutive data grants while if_req pending before fetch is forced (≥1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held until if_ready or flush
if_addr  in  32  fetch address (PC)
if_ready  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched instruction
if_busy  out  1  fetch pending; drives PC busy
flush  in  1  redirect (jmp/branch taken); kills pending/in-flight fetch
d_req  in  1  data request; held until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  32  data address
d_wdata  in  32  store data
d_size  in  3  access size in bytes (1,2,4)
d_ready  out  1  one-cycle pulse, access complete
d_rdata  out  32  load data
err  out  1  one-cycle pulse with ready on timeout
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_size  out  3  memory access size
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, single cycle

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; wait/starve counters 0; drop flag 0. A transaction in flight is abandoned; a later stray mem_ack is ignored.
- States:
  - IDLE, FETCH, DATA, RESP.
  - All mem_* outputs and ready/err/data outputs are registered.
- IDLE grant:
  - If d_req and not (starve==STARVE_LIMIT and if_req): grant data. Latch d_we/d_addr/d_wdata/d_size to mem_*, mem_req←1, go to DATA.
  - Else if if_req and not flush: grant fetch. mem_addr←if_addr, mem_we←0, mem_size←3'd4, mem_req←1, go to FETCH.
  - if_req together with flush in IDLE: no grant.
- Starve counter:
  - +1 on each data grant while if_req is high, saturating at STARVE_LIMIT.
  - Cleared on any fetch grant.
- FETCH/DATA:
  - mem_req and mem_* stay stable until mem_ack.
  - On mem_ack: capture mem_rdata, mem_req←0, go to RESP.
  - Ack on the first mem_req cycle is legal.
- Timeout:
  - Wait counter counts cycles with mem_req=1 and mem_ack=0.
  - On reaching MAX_WAIT: mem_req←0, captured data←0, err pulses in RESP.
- RESP (one cycle):
  - Pulse if_ready or d_ready for the owner, with data and err; then go to IDLE.
  - Requests are not sampled in RESP. The requester updates or drops its req at the edge ending RESP.
- Flush:
  - flush in FETCH sets the drop flag. The access still completes on the memory side.
  - With the drop flag set, RESP does not pulse if_ready and does not pulse err.
  - flush has no effect on DATA or on data requests. Drop flag clears on entering IDLE.
- if_busy = if_req & ~if_ready, combinational from registered if_ready.
- Latency: req seen at IDLE cycle 0 → mem_req cycle 1 → ack cycle 1 earliest → ready cycle 2 → IDLE cycle 3. Minimum 3 cycles per access, one access outstanding.
- mem_ack outside FETCH/DATA is ignored.

Test Plan:
- Single fetch: if_req=1, if_addr=0x8002_0000, ack after 2 cycles with 0x2402_0005 → mem_addr=0x8002_0000, mem_size=4, if_ready one cycle with if_data=0x2402_0005, if_busy low the cycle after.
- Simultaneous requests: if_req and d_req (store 0x1000_0010, data 0xDEAD_BEEF, size 4) same cycle, zero-wait ack → store issued first (mem_we=1), d_ready; fetch granted on next IDLE.
- Starvation: d_req continuously high and if_req pending, STARVE_LIMIT=4 → exactly 4 data grants, then one fetch grant, then data resumes.
- Flush in flight: fetch of 0x8002_0004 in FETCH, flush pulse, ack 3 cycles later → no if_ready. Next fetch to the new PC 0x8002_0040 is issued afterward and returns normally.
- Timeout: load 0x2000_0000, no ack, MAX_WAIT=16 → mem_req drops after 16 cycles, d_ready and err pulse together, d_rdata=0.
- Async reset mid-DATA: rst asserted between edges → mem_req and all outputs 0 immediately. After release, a late mem_ack produces no ready, and the next request starts normally.
